// File: rtl/bus_write_arbiter.sv
// bus_write_arbiter
//
// Purpose: shares the single memory-mapped write bus between master 0 (pipeline)
// and master 1 (secondary writer, e.g. debug loader or DMA). Arbitration is
// round-robin. The grant is registered and held until the write completes. Each
// granted write is routed to either the UART transmitter or a generic sink. The
// route is chosen by decoding the address. Data is not buffered: it passes
// combinationally from the owning master to the selected target.
//
// Optional feature: define BUS_ARB_TIMEOUT_EN to abort a grant that has waited
// TIMEOUT_CYCLES owned cycles without acceptance. Without the macro, err is tied
// to 0 and a grant is held until the write completes.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   m0_addr/data/valid  master 0 write request;  m0_ready  accepted/retired
//   m1_addr/data/valid  master 1 write request;  m1_ready  accepted/retired
//   tx_data/tx_valid    UART byte request;       tx_ready  UART can accept
//   s_addr/s_data/s_valid  sink write request;   s_ready   sink can accept
//   err                 one-cycle timeout abort pulse
module bus_write_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_data,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_data,
  input  logic        m1_valid,
  output logic        m1_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_data,
  output logic        s_valid,
  input  logic        s_ready,
  output logic        err
);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e      state_q;
  logic        last_q;     // index of the most recently granted master
  logic        own_valid;
  logic [31:0] own_addr;
  logic [31:0] own_data;
  logic        is_uart;
  logic        req_tx;
  logic        req_s;
  logic        done;
  logic        abort;
  logic        xfer_end;
  logic        tmo_hit;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;

  assign tmo_hit = (state_q != StIdle) && (cnt_q == CntW'(TIMEOUT_CYCLES));

  // Cleared while idle so every grant starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == StIdle) begin
      cnt_q <= '0;
    end else if (!xfer_end) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end
`else
  logic unused_timeout;

  assign tmo_hit        = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Owner mux; everything reads zero while idle.
  always_comb begin
    own_valid = 1'b0;
    own_addr  = '0;
    own_data  = '0;
    case (state_q)
      StOwn0: begin
        own_valid = m0_valid;
        own_addr  = m0_addr;
        own_data  = m0_data;
      end
      StOwn1: begin
        own_valid = m1_valid;
        own_addr  = m1_addr;
        own_data  = m1_data;
      end
      default: ;
    endcase
  end

  // In the timeout cycle the target valids are dropped unconditionally. The
  // abort therefore never depends on target ready, and no ready->valid path
  // exists. With the valids at 0, no completion can occur in that cycle.
  always_comb begin
    is_uart  = (own_addr[27:4] == 24'hFF_FFFF);
    req_tx   = own_valid && is_uart && !tmo_hit;
    req_s    = own_valid && !is_uart && !tmo_hit;
    done     = (req_tx && tx_ready) || (req_s && s_ready);
    abort    = tmo_hit && own_valid;
    xfer_end = done || abort;

    tx_valid = req_tx;
    s_valid  = req_s;
    tx_data  = own_data[7:0];
    s_addr   = own_addr;
    s_data   = own_data;
    m0_ready = (state_q == StOwn0) && xfer_end;
    m1_ready = (state_q == StOwn1) && xfer_end;
    err      = abort;
  end

  // Grant FSM. last resets to 1, so master 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (m0_valid && m1_valid) begin
            state_q <= last_q ? StOwn0 : StOwn1;
            last_q  <= !last_q;
          end else if (m0_valid) begin
            state_q <= StOwn0;
            last_q  <= 1'b0;
          end else if (m1_valid) begin
            state_q <= StOwn1;
            last_q  <= 1'b1;
          end
        end
        StOwn0, StOwn1: begin
          // An owner that withdraws its request is released without a transfer.
          if (xfer_end || !own_valid) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/bus_write_arbiter.md
# bus_write_arbiter

Shares the core's single memory-mapped write bus between two masters: port 0, the pipeline, and port 1, a secondary writer such as a debug loader or DMA. It also routes each granted write to one of two targets, the UART transmitter or a generic write sink. The block sits between `base_pipeline` plus the secondary master on one side and `uart_dev` plus the sink on the other, and replaces the ad-hoc decode/ready logic in the top level. Arbitration is round-robin with a registered grant held until the write completes.

## Interface
- `TIMEOUT_CYCLES`, 255: granted cycles without acceptance before abort (only with `BUS_ARB_TIMEOUT_EN`); ≥1.
- `clk` input 1: clock; all state on rising edge.
- `rst` input 1: reset; synchronous and active-high.
- `m0_addr` input 32: master 0 write address.
- `m0_data` input 32: master 0 write data.
- `m0_valid` input 1: master 0 write request.
- `m0_ready` output 1: master 0 write accepted/retired.
- `m1_addr` input 32: master 1 write address.
- `m1_data` input 32: master 1 write data.
- `m1_valid` input 1: master 1 write request.
- `m1_ready` output 1: master 1 write accepted/retired.
- `tx_data` output 8: UART byte, `data[7:0]` of the owner.
- `tx_valid` output 1: UART write request.
- `tx_ready` input 1: UART can accept.
- `s_addr` output 32: sink write address.
- `s_data` output 32: sink write data.
- `s_valid` output 1: sink write request.
- `s_ready` input 1: sink can accept.
- `err` output 1: one-cycle timeout abort pulse; tied 0 without macro.

## Operation
- States: IDLE, OWN0, OWN1. Register `last` records the last granted master; reset value 1, so master 0 wins first contention.
- IDLE transitions:
  - both valid → grant `!last`;
  - only mX valid → OWNX;
  - none → stay.
- On any grant, `last` ← granted index.
- OWNX:
  - Decode: `is_uart` = `mX_addr[27:4] == 24'hFF_FFFF`.
  - `tx_valid` = `mX_valid && is_uart`; `s_valid` = `mX_valid && !is_uart`.
  - `s_addr`/`s_data`/`tx_data` always mux from the owner; they are don't-care when the matching valid is 0, and forced 0 in IDLE.
  - `mX_ready` = completion = (`tx_valid && tx_ready`) || (`s_valid && s_ready`). The non-owner's ready is 0.
  - On completion → IDLE.
  - If the owner drops `mX_valid` while granted → IDLE next cycle, no transfer (protocol violation, tolerated).
- Masters hold addr/data/valid stable from assertion until ready. The arbiter never drops a grant before completion, except on timeout or reset.
- No buffering: data passes combinationally from the owner to the target.

## Timing
- Reset values: state IDLE, `last`=1, timeout counter 0. All outputs (`m0_ready`, `m1_ready`, `tx_valid`, `s_valid`, `err`, `tx_data`, `s_addr`, `s_data`) are 0.
- Request seen in IDLE at cycle N → grant at N+1 → earliest completion at N+1 (target ready) → IDLE at N+2.
- Minimum period is 2 cycles per write.
- Worst-case wait for a continuously requesting master is one other master's transfer plus 2 cycles.
- Ready/valid into targets are combinational from registered state plus master inputs. There is no combinational path from target ready to target valid.
- `rst` mid-transfer: next cycle in IDLE, all valids/readies 0, in-flight write dropped without ready.
- Simultaneous requests arriving in the same cycle a transfer completes are not arbitrated until the IDLE cycle that follows.

## Configuration
- `BUS_ARB_TIMEOUT_EN` defined:
  - Counter width `$clog2(TIMEOUT_CYCLES+1)`, cleared on grant, incremented each owned cycle without completion.
  - When the counter equals `TIMEOUT_CYCLES` and no completion occurs in that cycle, the arbiter aborts:
    - forces `tx_valid`/`s_valid` to 0;
    - asserts owner `mX_ready`=1 to release the master;
    - pulses `err`=1 for that cycle;
    - goes to IDLE.
- Not defined: no counter, `err` constant 0, a grant is held indefinitely until completion.

## Test plan
- Single UART write: m0 writes addr 0x0FFF_FFF0, data 0x41 at cycle 1, `tx_ready`=1 → `tx_valid`=1, `tx_data`=0x41, `m0_ready`=1 at cycle 2; IDLE at cycle 3; `s_valid` never set.
- Contention after reset: m0 and m1 both valid to sink addr 0x100, `s_ready`=1 → m0 completes at cycle 2, m1 at cycle 4; repeat both → m0 at 6, m1 at 8 (alternation).
- Backpressure: m1 UART write with `tx_ready` low 5 cycles → `tx_valid` held with stable `tx_data`, `m1_ready`=0 for 5 cycles; `m1_ready`=1 in the cycle `tx_ready` rises; m0 request meanwhile is not granted until after.
- Reset mid-transfer: grant m0 to sink with `s_ready`=0, assert `rst` one cycle → next cycle all outputs 0, state IDLE; following m1 request is granted first only if m0 is idle (`last`=1 after reset, so m0 wins contention).
- Timeout (macro on, `TIMEOUT_CYCLES`=4): sink write with `s_ready` stuck 0 → `err`=1 and `m0_ready`=1 on the 5th owned cycle, `s_valid`=0 that cycle, IDLE next. Macro off → no `err`, waits indefinitely.
